// File: rtl/amds_uart_byte_rx.sv
// Single-byte UART receiver (start, 8 data LSB first, parity, stop) for one AMDS data lane.
// Armed by start_rx; reports exactly one one-cycle result: valid byte, corrupt byte or timeout.
module amds_uart_byte_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int TIMEOUT_CLKS = 1000,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       start_rx,
    output logic       is_byte_valid,
    output logic       is_byte_corrupt,
    output logic       is_rx_timeout,
    output logic [7:0] dout,
    output logic [2:0] state_o
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF     = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]   LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CLKS - 1);
    localparam logic            PODD     = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, din_s_q;
    logic [15:0]     tmo_q, tmo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            corrupt_q, corrupt_d;
    logic            tmo_pulse_q, tmo_pulse_d;

    // Both synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            din_s_q <= 1'b1;
        end else begin
            sync1_q <= din;
            din_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            corrupt_q   <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            corrupt_q   <= corrupt_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        corrupt_d   = 1'b0;
        tmo_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_rx) begin
                    state_d = S_WAIT_START;
                    tmo_d   = '0;
                end
            end
            S_WAIT_START: begin
                tmo_d = tmo_q + 16'd1;
                cnt_d = '0;
                // A start bit seen on the expiry cycle still wins over the timeout.
                if (!din_s_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = S_IDLE;
                    tmo_pulse_d = 1'b1;
                end
            end
            S_START: begin
                // A high mid-bit sample is a glitch; the timeout count is kept, not restarted.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = din_s_q ? S_WAIT_START : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {din_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = din_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    dout_d  = shift_q;
                    if (((^shift_q) ^ par_q) == PODD && din_s_q) valid_d   = 1'b1;
                    else                                          corrupt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign is_byte_valid   = valid_q;
    assign is_byte_corrupt = corrupt_q;
    assign is_rx_timeout   = tmo_pulse_q;
    assign dout            = dout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_amds_uart_byte_rx.sv
// Bench for amds_uart_byte_rx: table vectors, hand-written corner sequences and randomized frames,
// with every result strobe checked against a cycle-exact expectation queue.
module tb_amds_uart_byte_rx;

    localparam int CPB  = 8;
    localparam int TMO  = 200;
    localparam int PODD = 0;
    localparam int FRAME_TO_STROBE = 3 + CPB / 2 + 10 * CPB + 1;
    localparam logic [1:0] K_VALID = 2'd1, K_CORRUPT = 2'd2, K_TMO = 2'd3;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic       start_rx = 1'b0;
    logic       is_byte_valid, is_byte_corrupt, is_rx_timeout;
    logic [7:0] dout;
    logic [2:0] state_o;

    amds_uart_byte_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .start_rx(start_rx),
        .is_byte_valid(is_byte_valid), .is_byte_corrupt(is_byte_corrupt),
        .is_rx_timeout(is_rx_timeout), .dout(dout), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [7:0] last_dout = 8'h00;

    // ---------------- scoreboard ----------------
    logic [41:0] exp_q[$];
    logic [41:0] got_w, exp_w;
    logic [1:0]  got_k;

    function automatic void push_exp(input logic [1:0] k, input logic [7:0] d, input int c);
        logic [31:0] c32;
        c32 = c;
        exp_q.push_back({k, d, c32});
    endfunction

    always @(negedge clk) begin
        if (is_byte_valid || is_byte_corrupt || is_rx_timeout) begin
            got_k = is_byte_valid ? K_VALID : (is_byte_corrupt ? K_CORRUPT : K_TMO);
            got_w = {got_k, dout, cyc[31:0]};
            total++;
            if (32'(is_byte_valid) + 32'(is_byte_corrupt) + 32'(is_rx_timeout) > 1) begin
                bad++;
                $display("FAIL onehot: got valid=%0b corrupt=%0b timeout=%0b at cyc=%0d, expected at most one",
                         is_byte_valid, is_byte_corrupt, is_rx_timeout, cyc);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got kind=%0d dout=%02h cyc=%0d, expected no strobe",
                         got_k, dout, cyc);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    bad++;
                    $display("FAIL strobe: got kind=%0d dout=%02h cyc=%0d, expected kind=%0d dout=%02h cyc=%0d",
                             got_w[41:40], got_w[39:32], got_w[31:0], exp_w[41:40], exp_w[39:32], exp_w[31:0]);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ 1'(PODD);
    endfunction

    function automatic logic [1:0] frame_kind(input logic [7:0] d, input logic p, input logic s);
        return (s && (((^d) ^ p) == 1'(PODD))) ? K_VALID : K_CORRUPT;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    // Returns so that the next posedge starts cycle c.
    task automatic goto_cyc(input int c);
        while (cyc < c - 1) begin @(posedge clk); #1; end
    endtask

    task automatic arm(output int n);
        @(posedge clk); #1;
        start_rx = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        start_rx = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic rearm, output int m);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        m = 0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk); #1;
                if (c == 0) din = bits[b];
                if (b == 0 && c == 0) begin
                    m = cyc;
                    start_rx = rearm;
                end else begin
                    start_rx = 1'b0;
                end
            end
        end
    endtask

    task automatic drained(input string name);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin @(posedge clk); #1; end
        idle(10);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [1:0] exp_kind;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n, m, mm, g;
        logic [7:0] d;
        logic p, s;

        tbl[0] = '{8'h91, 1'b1, 1'b1, K_VALID};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, K_CORRUPT};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, K_CORRUPT};
        tbl[3] = '{8'h00, 1'b0, 1'b1, K_VALID};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, K_VALID};
        tbl[5] = '{8'h01, 1'b0, 1'b1, K_CORRUPT};
        tbl[6] = '{8'h80, 1'b1, 1'b1, K_VALID};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(is_byte_valid), 0);
        check("rst_corrupt", 32'(is_byte_corrupt), 0);
        check("rst_timeout", 32'(is_rx_timeout), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        rst_n = 1'b1;
        idle(3);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            arm(n);
            m = n + 6;
            push_exp(tbl[i].exp_kind, tbl[i].data, m + FRAME_TO_STROBE);
            last_dout = tbl[i].data;
            goto_cyc(m);
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, 1'b0, mm);
            din = 1'b1;
            idle(4);
        end
        drained("table_drain");

        // Timeout with line idle; then an un-armed frame must be ignored
        arm(n);
        push_exp(K_TMO, last_dout, n + TMO + 1);
        idle(TMO + 5);
        check("tmo_state_idle", 32'(state_o), 32'(ST_IDLE));
        check("tmo_dout_hold", 32'(dout), 32'(last_dout));
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b0, mm);
        drained("tmo_drain");

        // Start bit on the last legal cycle wins; one cycle later is a timeout
        arm(n);
        m = n + TMO - 2;
        push_exp(K_VALID, 8'h6B, m + FRAME_TO_STROBE);
        last_dout = 8'h6B;
        goto_cyc(m);
        send_frame(8'h6B, good_par(8'h6B), 1'b1, 1'b0, mm);
        idle(4);
        arm(n);
        m = n + TMO - 1;
        push_exp(K_TMO, last_dout, n + TMO + 1);
        goto_cyc(m);
        send_frame(8'hC4, good_par(8'hC4), 1'b1, 1'b0, mm);
        drained("edge_drain");

        // Glitches: rejected, timeout count held (not restarted) across the START visit
        for (int i = 0; i < 3; i++) begin
            arm(n);
            goto_cyc(n + 50);
            @(posedge clk); #1; din = 1'b0;
            idle(2); din = 1'b1;
            m = (i == 0) ? n + 120 : (i == 1) ? n + 190 : n + TMO + 20;
            if (i < 2) begin
                push_exp(K_VALID, 8'hA5, m + FRAME_TO_STROBE);
                last_dout = 8'hA5;
            end else begin
                push_exp(K_TMO, last_dout, n + TMO + 1 + CPB / 2 + 1);
            end
            goto_cyc(m);
            send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b0, mm);
            idle(4);
        end
        drained("glitch_drain");

        // Back-to-back frames, re-armed in each strobe cycle
        arm(n);
        m = n + 5;
        push_exp(K_VALID, 8'h90, m + FRAME_TO_STROBE);
        push_exp(K_VALID, 8'h12, m + 11 * CPB + FRAME_TO_STROBE);
        push_exp(K_VALID, 8'h34, m + 22 * CPB + FRAME_TO_STROBE);
        goto_cyc(m);
        send_frame(8'h90, good_par(8'h90), 1'b1, 1'b0, mm);
        send_frame(8'h12, good_par(8'h12), 1'b1, 1'b1, mm);
        send_frame(8'h34, good_par(8'h34), 1'b1, 1'b1, mm);
        last_dout = 8'h34;
        drained("b2b_drain");

        // Reset during data bit 4 aborts silently and clears outputs
        arm(n);
        m = n + 5;
        goto_cyc(m);
        fork
            send_frame(8'hC3, good_par(8'hC3), 1'b1, 1'b0, mm);
            begin
                goto_cyc(m + 45);
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                check("mid_rst_valid", 32'(is_byte_valid), 0);
                check("mid_rst_corrupt", 32'(is_byte_corrupt), 0);
                check("mid_rst_timeout", 32'(is_rx_timeout), 0);
                check("mid_rst_dout", 32'(dout), 0);
                check("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        join
        last_dout = 8'h00;
        idle(4);
        arm(n);
        m = n + 5;
        push_exp(K_VALID, 8'h55, m + FRAME_TO_STROBE);
        last_dout = 8'h55;
        goto_cyc(m);
        send_frame(8'h55, good_par(8'h55), 1'b1, 1'b0, mm);
        drained("rst_drain");

        // Randomized frames, gaps and errors against the model
        for (int i = 0; i < 14; i++) begin
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            s = ($urandom_range(0, 5) != 0);
            g = $urandom_range(0, TMO + 8);
            arm(n);
            m = n + 2 + g;
            if (m <= n + TMO - 2) begin
                push_exp(frame_kind(d, p, s), d, m + FRAME_TO_STROBE);
                last_dout = d;
            end else begin
                push_exp(K_TMO, last_dout, n + TMO + 1);
            end
            goto_cyc(m);
            send_frame(d, p, s, 1'b0, mm);
            din = 1'b1;
            idle(12);
        end
        drained("rand_drain");
        check("final_dout", 32'(dout), 32'(last_dout));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
